// File: rtl/multiphase_clk_gen_if.sv
// Configuration handshake bundle for the multiphase clock generator.
interface multiphase_clk_gen_if #(
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_half;
  logic [CNT_W-1:0] cfg_step;
  logic             cfg_err;

  modport master (output cfg_valid, cfg_half, cfg_step, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_half, cfg_step, output cfg_ready, cfg_err);
endinterface

// File: rtl/multiphase_clk_gen.sv
// Multiphase clock generator: PHASES square waves of period 2H, phase k delayed k*S cycles.
// New half-period/step settings are staged and only take effect at a period boundary.
//
// state | meaning
// IDLE  | outputs low, counter parked; a pending config is applied on any edge
// RUN   | counter sweeps 0..H-1 twice per period; exits only at a period boundary
module multiphase_clk_gen #(
  parameter int PHASES   = 10,
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 10,
  parameter int DEF_STEP = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  multiphase_clk_gen_if.slave   cfg,
  output logic [PHASES-1:0]     clk_out,
  output logic                  period_start,
  output logic                  running
);

  localparam int PW = $clog2(PHASES);
  localparam int EW = CNT_W + PW;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state;
  logic [CNT_W-1:0]   counter;
  logic               half_flag;
  logic [CNT_W-1:0]   half_r;
  logic [CNT_W-1:0]   step_r;
  logic [CNT_W-1:0]   pend_half;
  logic [CNT_W-1:0]   pend_step;
  logic               pending;
  logic               err_r;

  logic [EW-1:0]      span;
  logic               legal;
  logic               take;
  logic               boundary;
  logic               wrap;
  logic [PHASES-1:0]  toggle;

  // Span of the last phase is computed wide so large steps cannot alias into range.
  assign span     = EW'(PHASES - 1) * EW'(cfg.cfg_step);
  assign legal    = (cfg.cfg_half >= CNT_W'(2)) && (cfg.cfg_step != '0) &&
                    (span < EW'(cfg.cfg_half));
  assign take     = cfg.cfg_valid && !pending;
  assign wrap     = (counter == half_r - CNT_W'(1));
  assign boundary = wrap && half_flag;

  always_comb begin
    toggle = '0;
    for (int k = 0; k < PHASES; k++) begin
      toggle[k] = (EW'(counter) == EW'(k) * EW'(step_r));
    end
  end

  assign cfg.cfg_ready = !pending;
  assign cfg.cfg_err   = err_r;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= IDLE;
      counter      <= '0;
      half_flag    <= 1'b0;
      clk_out      <= '0;
      period_start <= 1'b0;
      running      <= 1'b0;
      err_r        <= 1'b0;
      pending      <= 1'b0;
      pend_half    <= '0;
      pend_step    <= '0;
      half_r       <= CNT_W'(DEF_HALF);
      step_r       <= CNT_W'(DEF_STEP);
    end else begin
      err_r        <= take && !legal;
      period_start <= 1'b0;
      if (take && legal) begin
        pending   <= 1'b1;
        pend_half <= cfg.cfg_half;
        pend_step <= cfg.cfg_step;
      end
      case (state)
        IDLE: begin
          counter   <= '0;
          half_flag <= 1'b0;
          clk_out   <= '0;
          if (pending) begin
            half_r  <= pend_half;
            step_r  <= pend_step;
            pending <= 1'b0;
          end
          if (enable) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          period_start <= (counter == '0) && !half_flag;
          if (wrap) begin
            counter   <= '0;
            half_flag <= ~half_flag;
          end else begin
            counter <= counter + CNT_W'(1);
          end
          if (boundary) begin
            // Every phase has already fallen by here; clearing keeps the next period clean.
            clk_out <= '0;
            if (pending) begin
              half_r  <= pend_half;
              step_r  <= pend_step;
              pending <= 1'b0;
            end
            if (!enable) begin
              state   <= IDLE;
              running <= 1'b0;
            end
          end else begin
            clk_out <= clk_out ^ toggle;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/multiphase_clk_gen.md
MULTIPHASE_CLK_GEN -- requirements
Module: multiphase_clk_gen

Interface
REQ-001 SHALL provide parameter PHASES, default 10: number of phase outputs; legal range >=2.
REQ-002 SHALL provide parameter CNT_W, default 8: width of the half-period and step fields.
REQ-003 SHALL provide parameter DEF_HALF, default 10: half-period in clock cycles applied at reset.
REQ-004 SHALL provide parameter DEF_STEP, default 1: phase-to-phase spacing in clock cycles applied at reset.
REQ-005 SHALL have port clock, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-007 SHALL have port enable, input, 1 bit: run request.
REQ-008 SHALL have port cfg_valid, input, 1 bit: configuration offer.
REQ-009 SHALL have port cfg_ready, output, 1 bit: configuration slot free.
REQ-010 SHALL have port cfg_half, input, CNT_W bits: requested half-period H.
REQ-011 SHALL have port cfg_step, input, CNT_W bits: requested phase step S.
REQ-012 SHALL have port cfg_err, output, 1 bit: one-cycle pulse flagging a rejected configuration.
REQ-013 SHALL have port clk_out, output, PHASES bits: phase clocks.
REQ-014 SHALL have port period_start, output, 1 bit: one-cycle pulse coincident with each clk_out[0] rise.
REQ-015 SHALL have port running, output, 1 bit: high while in RUN.

Function
REQ-016 SHALL implement FSM IDLE/RUN: IDLE->RUN on an edge sampling enable=1; RUN->IDLE only at a period boundary with enable=0.
REQ-017 SHALL, in IDLE, hold counter=0, half flag=0, clk_out=0.
REQ-018 SHALL, on each RUN edge, toggle clk_out[k] when counter==k*S, evaluated at full width (no wrap); counter then increments, wrapping H-1->0 and inverting the half flag.
REQ-019 SHALL define the period boundary as counter==H-1 with half flag=1; all clk_out are 0 after this edge, so every output has period 2H, duty H/2H, and phase k lags phase 0 by k*S cycles.
REQ-020 SHALL, with enable deasserted mid-period, complete the current period and leave no partial pulse.
REQ-021 SHALL hold cfg_ready=1 while no configuration is pending; transfer occurs on cfg_valid&cfg_ready.
REQ-022 SHALL accept a configuration as legal iff H>=2, S>=1 and (PHASES-1)*S < H, computed at CNT_W+clog2(PHASES) bits.
REQ-023 SHALL, for an illegal transfer, pulse cfg_err high for the following cycle, discard the configuration, and keep cfg_ready=1.
REQ-024 SHALL, for a legal transfer, store it as pending and drive cfg_ready=0 until it is applied.
REQ-025 SHALL apply a pending configuration at the next period boundary in RUN, or on the next edge in IDLE; cfg_ready returns to 1 the cycle after.
REQ-026 SHALL not apply a configuration accepted on a boundary edge at that same boundary; it waits for the next boundary.
REQ-027 SHALL ignore cfg_valid while cfg_ready=0; the offer is neither stored nor flagged.
REQ-028 SHALL drive period_start registered, high for the same cycle in which clk_out[0] first reads 1 in each period.

Reset
REQ-029 SHALL, on any edge with reset=0, set state=IDLE, counter=0, half flag=0, clk_out=0, period_start=0, running=0, cfg_err=0, cfg_ready=1, H=DEF_HALF, S=DEF_STEP, and clear any pending configuration, including mid-period.

Verification
REQ-030 SHALL cover default parameters, enable high sampled at edge E0: running=1 after E0, clk_out[0]=1 after E1, clk_out[k] rises after E1+k, all periods are 20 cycles at 50% duty, and period_start pulses every 20 cycles.
REQ-031 SHALL cover running when cfg H=20, S=2 is accepted: cfg_ready=0 until the boundary; the next period is 40 cycles with phase k lagging 2k cycles; cfg_ready=1 after.
REQ-032 SHALL cover cfg H=8, S=1 (9>=8): cfg_err is a 1-cycle pulse, timing is unchanged, and cfg_ready stays 1.
REQ-033 SHALL cover enable dropped 3 cycles into a period: outputs finish the full 20-cycle period, then clk_out=0, running=0, and no further toggles occur.
REQ-034 SHALL cover reset=0 mid-period with a config pending: the next edge shows clk_out=0 and cfg_ready=1; restarting yields the default 20-cycle timing.
REQ-035 SHALL cover a second cfg_valid while one is pending: no acceptance and no cfg_err; only the first configuration takes effect.
